// File: rtl/data_memory_pipe_if.sv
// Request/response bus for data_memory_pipe.
// master = requester, slave = memory.
interface data_memory_pipe_if #(
  parameter int AW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_ctrl;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_ctrl, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_pipe.sv
// Byte-addressed little-endian data memory, one request per 2 cycles.
// Define DATA_MEMORY_PIPE_ALIGN_CHECK_EN to reject misaligned half/word.
module data_memory_pipe #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_pipe_if.slave bus
);
  localparam int IW = $clog2(DEPTH_BYTES);

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [IW-1:0] lane [4];
  logic [7:0]    rb [4];

  logic        is_b, is_h, is_w;
  logic        misal, err, accept;
  logic        sx;
  logic [3:0]  be;
  logic [31:0] ld;
  logic        unused_addr;

  assign unused_addr = ^bus.req_addr;

  // Each lane wraps on its own, so a word may straddle the top.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = bus.req_addr[IW-1:0] + IW'(i);
      rb[i]   = mem_q[lane[i]];
    end
  end

  assign is_b = (bus.req_ctrl[1:0] == 2'b00);
  assign is_h = (bus.req_ctrl[1:0] == 2'b01);
  assign is_w = (bus.req_ctrl == 3'b010);
  assign sx   = ~bus.req_ctrl[2];

`ifdef DATA_MEMORY_PIPE_ALIGN_CHECK_EN
  assign misal = (is_h & bus.req_addr[0])
               | (is_w & (|bus.req_addr[1:0]));
`else
  assign misal = 1'b0;
`endif

  assign err    = ~(is_b | is_h | is_w) | misal;
  assign accept = (state_q == IDLE)
                & bus.req_valid & ~rst;

  always_comb begin
    be = 4'b0000;
    ld = 32'h0;
    unique case (1'b1)
      is_w: begin
        be = 4'b1111;
        ld = {rb[3], rb[2], rb[1], rb[0]};
      end
      is_h: begin
        be = 4'b0011;
        ld = {{16{sx & rb[1][7]}}, rb[1], rb[0]};
      end
      is_b: begin
        be = 4'b0001;
        ld = {{24{sx & rb[0][7]}}, rb[0]};
      end
      default: begin
        be = 4'b0000;
        ld = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          err_d   = err;
          rdata_d = (err | bus.req_we) ? 32'h0 : ld;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rdata_d = 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (accept & bus.req_we & ~err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[lane[i]] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 The block SHALL have exactly one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 Parameter DEPTH_BYTES SHALL default to 1024 and set the byte-addressed storage size, which SHALL be a power of two and at least 4.
REQ-003 Parameter AW SHALL default to 32 and set the request address width.
REQ-004 clk  input  1  rising-edge clock for all state and storage.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  AW  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_ctrl  input  3  size code: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  32  load result; 0 for stores and for errors.
REQ-015 rsp_err  output  1  request was rejected.

Function
REQ-016 The FSM SHALL have two states: IDLE and RESP.
REQ-017 req_ready SHALL equal 1 in IDLE and 0 in RESP.
REQ-018 A request SHALL be accepted at a rising edge where the state is IDLE and req_valid=1; acceptance SHALL move the FSM to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL hold stable until the handshake completes.
REQ-020 A rising edge in RESP with rsp_ready=1 SHALL return the FSM to IDLE and clear rsp_valid; there is no bypass, so peak throughput is one request per 2 cycles.
REQ-021 Latency from acceptance edge to rsp_valid=1 SHALL be 1 cycle.
REQ-022 Storage is little-endian; the effective byte address SHALL be req_addr modulo DEPTH_BYTES.
REQ-023 Each multi-byte lane SHALL independently wrap modulo DEPTH_BYTES.
REQ-024 A store SHALL commit atomically at the acceptance edge and modify only the addressed bytes: 1 byte for codes 000/100, 2 bytes for 001/101, 4 bytes for 010; all other bytes SHALL be unchanged.
REQ-025 A load SHALL sample storage at the acceptance edge and register the result into rsp_rdata.
REQ-026 Load results SHALL be sign-extended for codes 000/001, zero-extended for codes 100/101, and unmodified for code 010.
REQ-027 A load at the acceptance edge immediately following a store SHALL return the stored data.
REQ-028 Codes 011, 110 and 111 SHALL produce rsp_err=1 and rsp_rdata=0, with no storage change.
REQ-029 For a store, rsp_rdata SHALL be 0 and rsp_err SHALL be 0 unless an error applies.
REQ-030 req_valid while req_ready=0 SHALL be ignored; the requester holds the request.

Reset
REQ-031 While rst=1, regardless of clk: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-032 Reset asserted in RESP SHALL drop the pending response.
REQ-033 A store already committed before reset SHALL remain in storage; a request presented during reset SHALL NOT be accepted.
REQ-034 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-035 The macro is DATA_MEMORY_PIPE_ALIGN_CHECK_EN.
REQ-036 When DATA_MEMORY_PIPE_ALIGN_CHECK_EN is defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL produce rsp_err=1 and rsp_rdata=0, with no storage change.
REQ-037 When DATA_MEMORY_PIPE_ALIGN_CHECK_EN is undefined, misaligned accesses SHALL complete byte-wise per REQ-022/REQ-023 with rsp_err=0.

Verification
REQ-038 Store word 0xDEADBEEF @0x10, then load 010 @0x10 -> rsp_rdata=0xDEADBEEF; load 000 @0x10 -> 0xFFFFFFEF; load 100 @0x13 -> 0x000000DE.
REQ-039 Store word 0x11223344 @0x20, store byte 0xAA @0x21, then load word @0x20 -> 0x1122AA44 (adjacent bytes preserved).
REQ-040 Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; pulse rsp_ready -> IDLE next cycle.
REQ-041 DEPTH_BYTES=1024, store word 0xCAFEF00D @0x3FE with macro undefined -> bytes 0x3FE=0x0D, 0x3FF=0xF0, 0x000=0xFE, 0x001=0xCA; the same request with macro defined -> rsp_err=1 and storage unchanged.
REQ-042 req_ctrl=111 store -> rsp_err=1 and storage unchanged.
REQ-043 Assert rst asynchronously while in RESP -> rsp_valid=0 immediately; after release, req_ready=1 and the earlier store data is still readable.
